// File: rtl/row_window_loader.sv
// Captures a fixed column span of each pixel row into two ping-pong banks and presents finished windows with a valid/ack handshake.
// Optional ROW_WINDOW_NOISE_FLOOR_EN adds noise_floor: stored byte = max(pix_data - noise_floor, 0).
module row_window_loader #(
   parameter int WINDOW_LEN = 144,
   parameter int LINE_WIDTH = 640,
   parameter int WIN_START  = 248,
   parameter int ROW_BITS   = 10
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [7:0]              pix_data,
   input  logic                    pix_valid,
   input  logic                    pix_sol,
`ifdef ROW_WINDOW_NOISE_FLOOR_EN
   input  logic [7:0]              noise_floor,
`endif
   output logic [WINDOW_LEN*8-1:0] window,
   output logic [ROW_BITS-1:0]     win_row,
   output logic                    win_valid,
   input  logic                    win_ack,
   output logic                    dropped,
   output logic [15:0]             drop_count
);
   localparam int CW = $clog2(LINE_WIDTH + 1);
   localparam int IW = (WINDOW_LEN > 1) ? $clog2(WINDOW_LEN) : 1;
   localparam logic [CW-1:0] C_LO  = CW'(WIN_START);
   localparam logic [CW-1:0] C_HI  = CW'(WIN_START + WINDOW_LEN);
   localparam logic [CW-1:0] C_MAX = CW'(LINE_WIDTH);
   localparam logic [IW-1:0] C_LAST = IW'(WINDOW_LEN - 1);

   typedef enum logic [1:0] {ST_EMPTY, ST_FILLING, ST_FULL} bank_st_t;

   bank_st_t                        r_st [2];
   bank_st_t                        w_st_nxt [2];
   logic [WINDOW_LEN-1:0][7:0]      r_mem [2];
   logic [ROW_BITS-1:0]             r_tag [2];
   logic [ROW_BITS-1:0]             r_row;
   logic [CW-1:0]                   r_col;
   logic                            r_col_vld;
   logic                            r_q [2];
   logic [1:0]                      r_qcnt;
   logic                            r_push_vld, r_push_bank;
   logic                            r_dropped;
   logic [15:0]                     r_drop_count;

   logic [CW-1:0] w_col;
   logic [IW-1:0] w_idx;
   logic [7:0]    w_pix;
   logic          w_sol, w_in_win, w_valid, w_pop, w_drop;
   logic          w_claim_vld, w_claim, w_wr_vld, w_wr_bank, w_done;

   assign w_sol    = pix_valid && pix_sol;
   assign w_col    = pix_sol ? '0 : ((r_col == C_MAX) ? r_col : r_col + 1'b1);
   assign w_in_win = pix_valid && (pix_sol || r_col_vld) && (w_col >= C_LO) && (w_col < C_HI);
   assign w_idx    = IW'(w_col - C_LO);
   assign w_valid  = (r_qcnt != 2'd0);
   assign w_pop    = w_valid && win_ack;

`ifdef ROW_WINDOW_NOISE_FLOOR_EN
   assign w_pix = (pix_data > noise_floor) ? pix_data - noise_floor : 8'd0;
`else
   assign w_pix = pix_data;
`endif

   // All decisions use pre-edge bank state, so a bank freed by ack is not claimable this cycle.
   always_comb begin
      for (int b = 0; b < 2; b++) w_st_nxt[b] = r_st[b];
      w_drop      = 1'b0;
      w_claim_vld = 1'b0;
      w_claim     = 1'b0;
      w_wr_vld    = 1'b0;
      w_wr_bank   = 1'b0;
      w_done      = 1'b0;
      if (w_pop) w_st_nxt[r_q[0]] = ST_EMPTY;
      if (w_sol) begin
         for (int b = 0; b < 2; b++)
            if (r_st[b] == ST_FILLING) begin
               w_st_nxt[b] = ST_EMPTY;
               w_drop      = 1'b1;
            end
         if (r_st[0] != ST_FULL) begin
            w_claim_vld = 1'b1;
            w_claim     = 1'b0;
         end else if (r_st[1] != ST_FULL) begin
            w_claim_vld = 1'b1;
            w_claim     = 1'b1;
         end else begin
            w_drop = 1'b1;
         end
         if (w_claim_vld) w_st_nxt[w_claim] = ST_FILLING;
         w_wr_vld  = w_in_win && w_claim_vld;
         w_wr_bank = w_claim;
      end else begin
         w_wr_vld  = w_in_win && ((r_st[0] == ST_FILLING) || (r_st[1] == ST_FILLING));
         w_wr_bank = (r_st[0] != ST_FILLING);
      end
      if (w_wr_vld && (w_idx == C_LAST)) begin
         w_st_nxt[w_wr_bank] = ST_FULL;
         w_done              = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int b = 0; b < 2; b++) begin
            r_st[b]  <= ST_EMPTY;
            r_tag[b] <= '0;
            r_q[b]   <= 1'b0;
         end
         r_row        <= '0;
         r_col        <= '0;
         r_col_vld    <= 1'b0;
         r_qcnt       <= 2'd0;
         r_push_vld   <= 1'b0;
         r_push_bank  <= 1'b0;
         r_dropped    <= 1'b0;
         r_drop_count <= '0;
      end else begin
         for (int b = 0; b < 2; b++) r_st[b] <= w_st_nxt[b];
         if (pix_valid && (pix_sol || r_col_vld)) begin
            r_col     <= w_col;
            r_col_vld <= 1'b1;
         end
         if (w_sol) r_row <= r_row + 1'b1;
         if (w_claim_vld) r_tag[w_claim] <= r_row;
         r_dropped <= w_drop;
         if (w_drop && (r_drop_count != 16'hFFFF)) r_drop_count <= r_drop_count + 1'b1;
         // Completion enters the presentation order one cycle after the last write.
         r_push_vld  <= w_done;
         r_push_bank <= w_wr_bank;
         case ({r_push_vld, w_pop})
            2'b10: begin
               r_q[r_qcnt[0]] <= r_push_bank;
               r_qcnt         <= r_qcnt + 1'b1;
            end
            2'b01: begin
               r_q[0] <= r_q[1];
               r_qcnt <= r_qcnt - 1'b1;
            end
            2'b11: begin
               if (r_qcnt == 2'd2) begin
                  r_q[0] <= r_q[1];
                  r_q[1] <= r_push_bank;
               end else begin
                  r_q[0] <= r_push_bank;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk)
      if (w_wr_vld) r_mem[w_wr_bank][w_idx] <= w_pix;

   assign win_valid  = w_valid;
   assign window     = w_valid ? r_mem[r_q[0]] : '0;
   assign win_row    = w_valid ? r_tag[r_q[0]] : '0;
   assign dropped    = r_dropped;
   assign drop_count = r_drop_count;
endmodule
